// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: per-cycle (p, k, conf) op stream for one 5-stage radix-4 NTT/INTT pass
// Ports: clk, rst (sync, active-high); start/conf request a pass, conf latched on accept;
// stall holds the current op; busy/done frame the pass; valid/p/k/conf_out carry the op;
// stage_first/stage_last flag op 0 / op 255 of each stage. GAP sets idle cycles between stages.
module ntt_stage_sequencer #(
    parameter int GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] conf,
    input  logic       stall,
    output logic       busy,
    output logic       valid,
    output logic [2:0] p,
    output logic [7:0] k,
    output logic [2:0] conf_out,
    output logic       stage_first,
    output logic       stage_last,
    output logic       done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;
    logic [1:0] state_q, state_d;
    logic [2:0] p_q, p_d, conf_q, conf_d, p_next;
    logic [7:0] op_q, op_d;
    logic [3:0] gap_q, gap_d;
    logic       fwd, last_stage, consume;
    assign fwd        = conf_q == 3'b001 || conf_q == 3'b100;
    assign last_stage = fwd ? p_q == 3'd0 : p_q == 3'd4;
    assign p_next     = fwd ? p_q - 3'd1 : p_q + 3'd1;
    assign consume    = state_q == S_RUN && !stall;
    // op_idx is held at 255 on the final consume so k keeps its last value through FIN/IDLE
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        op_d    = op_q;
        conf_d  = conf_q;
        gap_d   = gap_q;
        if (state_q == S_IDLE && start && conf != 3'b000) begin
            state_d = S_RUN;
            conf_d  = conf;
            p_d     = (conf == 3'b001 || conf == 3'b100) ? 3'd4 : 3'd0;
            op_d    = 8'd0;
        end else if (consume && op_q != 8'hFF) begin
            op_d = op_q + 8'd1;
        end else if (consume && last_stage) begin
            state_d = S_FIN;
        end else if (consume && GAP == 0) begin
            p_d  = p_next;
            op_d = 8'd0;
        end else if (consume) begin
            state_d = S_GAP;
            gap_d   = 4'(GAP - 1);
            op_d    = 8'd0;
        end else if (state_q == S_GAP) begin
            state_d = gap_q == 4'd0 ? S_RUN : S_GAP;
            p_d     = gap_q == 4'd0 ? p_next : p_q;
            gap_d   = gap_q - 4'd1;
        end else if (state_q == S_FIN) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= 3'd0;
            op_q    <= 8'd0;
            conf_q  <= 3'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            op_q    <= op_d;
            conf_q  <= conf_d;
            gap_q   <= gap_d;
        end
    end
    assign busy        = state_q != S_IDLE;
    assign valid       = state_q == S_RUN;
    assign done        = state_q == S_FIN;
    assign p           = p_q;
    assign k           = op_q >> {p_q, 1'b0};
    assign conf_out    = conf_q;
    assign stage_first = valid && op_q == 8'd0;
    assign stage_last  = valid && op_q == 8'hFF;
endmodule

// File: doc/ntt_stage_sequencer.md
Name: ntt_stage_sequencer

Overview:
- Produces the per-cycle (p, k, conf) stream that drives the twiddle-factor address generator and the butterfly datapath for one full 5-stage radix-4 NTT/INTT pass of 256 butterfly ops per stage.
- Sits between the top-level controller (start/done) and the tf address generator / memory bank address logic.
- Honours a downstream stall and inserts a fixed pipeline-drain gap between stages.

Parameters:
- GAP, 4, idle cycles (valid=0) inserted between consecutive stages for pipeline drain; legal range 0..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- conf  input  3  operation config, latched at accepted start.
- stall  input  1  downstream hold; the current op is not consumed while high.
- busy  output  1  high from accepted start until done inclusive.
- valid  output  1  (p, k) is a live butterfly op.
- p  output  3  stage index.
- k  output  8  twiddle block index.
- conf_out  output  3  latched conf.
- stage_first  output  1  valid op is op_idx 0 of a stage.
- stage_last  output  1  valid op is op_idx 255 of a stage.
- done  output  1  one-cycle pulse at pass end.

Behaviour:
- Reset (sync, any state, including mid-pass): state=IDLE. busy, valid, done, stage_first and stage_last are 0. p=0, k=0, conf_out=0. Counters are 0.
- Mode: fwd = (latched conf==3'b001 || conf==3'b100); otherwise inverse.
- Stage order: fwd uses p=4,3,2,1,0. Inverse uses p=0,1,2,3,4.
- States: IDLE, RUN, GAP, FIN.
- IDLE:
  - start=1 with conf!=3'b000 is accepted. Latch conf, load p with the first stage, set op_idx=0, go to RUN.
  - start with conf==3'b000 is ignored.
  - Registered outputs: the first valid op appears the cycle after start.
- RUN:
  - valid=1. k = op_idx >> (2*p), zero-extended to 8 bits. So p=4 gives k=0, p=3 gives 0..3, p=2 gives 0..15, p=1 gives 0..63, p=0 gives 0..255.
  - An op is consumed on a cycle with valid && !stall. On consume, op_idx increments (8-bit).
  - While stall=1, p, k, op_idx and the flags hold unchanged.
  - Consuming op_idx=255 on a non-final stage: go to GAP if GAP>0, otherwise step p and stay in RUN with op_idx=0 (back-to-back, no bubble).
  - Consuming op_idx=255 on the final stage: go to FIN.
- GAP:
  - valid=0 for exactly GAP cycles.
  - The gap counter ignores stall.
  - Then step p (fwd p-1, inverse p+1), set op_idx=0, return to RUN.
- FIN:
  - done=1 and busy=1 for one cycle, valid=0, then go to IDLE.
  - p, k and conf_out keep their last values until the next start.
- stage_first = valid && op_idx==0. stage_last = valid && op_idx==255.
- start outside IDLE is ignored. Changes on conf after the start is accepted have no effect.
- Cycle count with no stall: 5*256 ops + 4*GAP + 1 (FIN), measured from the first valid cycle to the done cycle inclusive. With GAP=4 this is 1297.

Test Plan:
- NTT pass, no stall: start with conf=001, GAP=4.
  - First valid cycle: p=4, k=0.
  - Stage 3 ops 0..255 give k = op>>6 (0,0,...,3). Stage 0 gives k = op.
  - done exactly 1297 cycles after the first valid. valid=0 for exactly 4 cycles between stages.
- INTT pass: start with conf=010.
  - First op: p=0, k=0. op_idx=5 gives k=5.
  - Last stage is p=4 with k=0 throughout.
  - conf_out=010 for the whole pass.
- Stall: hold stall=1 for 3 cycles at p=1, op_idx=63 (k=15).
  - Outputs are frozen at k=15 while stalled. The next consumed op is op_idx=64 (k=16).
  - done is delayed by exactly 3 cycles.
- Stage boundaries:
  - GAP=0: stage 4 op 255 is followed directly by p=3 op 0 (stage_first=1), no bubble.
  - GAP=4: stall asserted during the gap does not extend it.
- Ignored starts:
  - start with conf=000 leaves busy=0.
  - start pulsed mid-pass does not restart; the op count is unchanged.
- Mid-pass reset: assert rst at p=2, op 100.
  - Next cycle: busy=0, valid=0, p=0, k=0, conf_out=0.
  - A subsequent start with conf=100 runs a clean forward pass.
